seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised multiplexed seven-segment scanner, the successor to the fixed 8-digit, binary-only tube driver. It time-multiplexes `DIGITS` common-anode digits from one clock, with full hex decode, per-digit enable and decimal point, and a blanking interval between digits against ghosting. Input data is snapshotted once per frame so a digit never tears mid-frame. It sits between the board clock domain (`CLK_50M`) and the display pins, fed by state/sequence logic.

## Interface
- `DIGITS`, 8: number of digits scanned, legal 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, legal 4..65535.
- `BLANK_CYC`, 64: cycles at slot start with all digits off, legal 1..`SCAN_DIV`-1.
- `CLK`  in  1  scan clock (board 50 MHz).
- `RESET_N`  in  1  asynchronous, active-low reset.
- `digit_data`  in  4*`DIGITS`  hex nibble per digit; digit i = bits [4i+3:4i].
- `digit_en`  in  `DIGITS`  1 = show nibble, 0 = show dash.
- `dp`  in  `DIGITS`  1 = light decimal point of digit i.
- `dataout`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `bit_out`  out  `DIGITS`  digit select, active-low, at most one bit low.
- `frame_start`  out  1  one-cycle pulse at first cycle of each frame.

## Operation
- Counters: slot counter `cnt` 0..`SCAN_DIV`-1; digit index `idx` 0..`DIGITS`-1. `cnt` wraps to 0 after `SCAN_DIV`-1 and `idx` advances; `idx` wraps `DIGITS`-1 -> 0.
- FSM per slot: BLANK (cnt < `BLANK_CYC`) -> DRIVE (cnt >= `BLANK_CYC`) -> BLANK of next slot.
- BLANK: `bit_out` all ones, `dataout` = 8'hFF.
- DRIVE: `bit_out[idx]` = 0, others 1; `dataout` = decode of snapshot digit `idx`.
- Snapshot: `digit_data`, `digit_en`, `dp` captured into shadow registers when cnt = 0 and idx = 0; all display uses shadow values only.
- Decode (bit7 = 1 before dp): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Disabled digit: 8'hBF (dash); dp still applied.
- dp = 1 clears bit7 of the pattern.

## Timing
- Reset (async assert, sync-safe release): `cnt`=0, `idx`=0, FSM BLANK, shadows 0, `dataout`=8'hFF, `bit_out`=all ones, `frame_start`=0.
- All outputs registered: output values reflect (idx, cnt) of the previous cycle, so latency is 1 cycle.
- First clock after reset release: counters at (0,0); `frame_start`=1 and shadows loaded at that edge's output. The pulse repeats every `DIGITS`*`SCAN_DIV` cycles.
- Each digit lit for `SCAN_DIV`-`BLANK_CYC` cycles per frame. The boundary between two digits always has `BLANK_CYC` all-off cycles, so no two select bits are ever low together.
- Inputs changing mid-frame: no effect until the next `frame_start`. Inputs changing on the snapshot edge are captured.
- Reset mid-slot: outputs go blank immediately (async), and scanning restarts at digit 0.
- `DIGITS`=1: `frame_start` fires every slot; the digit still blanks `BLANK_CYC` per slot.

## Configuration
- `SEG_SCAN_LEADZERO_EN` defined:
  - Leading-zero suppression on the snapshot.
  - An enabled digit i > 0 whose nibble is 0 is shown as 8'hFF (dp still applied) if every enabled digit above it is also 0 or disabled.
  - Digit 0 is never suppressed.
  - Disabled digits still show a dash and do not break the zero run.
- Macro undefined: zeros always display as C0; no suppression logic is compiled.

## Test plan
All with `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2 unless noted.
- Reset then release, data=16'h3A71, en=4'hF, dp=0:
  - `frame_start` high in cycle 1.
  - Cycles 1-2 `bit_out`=F, `dataout`=FF.
  - Cycles 3-8 `bit_out`=E, `dataout`=F9.
  - Then digit 1 shows F8, digit 2 shows 88, digit 3 shows B0.
  - `frame_start` again at cycle 33.
- Change data to 16'hFFFF at cycle 12 (mid-frame): digits 1-3 keep 3A71 values; 8E appears only after the next `frame_start`.
- en=4'b1011, dp=4'b0100: digit 2 shows 3F (dash with dp); others decode normally.
- Assert `RESET_N`=0 during DRIVE of digit 2: same cycle `bit_out`=F, `dataout`=FF; after release scanning restarts from digit 0 with a `frame_start` pulse.
- Check every cycle: `bit_out` never has more than one zero; each select edge is separated by ≥2 all-F cycles.
- With `SEG_SCAN_LEADZERO_EN`, data=16'h0050, en=F: digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0. Without the macro: C0, C0, 92, C0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: per-frame input snapshot, hex decode,
// per-digit blanking. Define SEG_SCAN_LEADZERO_EN for leading-zero suppression.
module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            dataout,
    output logic [DIGITS-1:0]     bit_out,
    output logic                  frame_start
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         sh_nib [DIGITS];
    logic [DIGITS-1:0]  sh_en;
    logic [DIGITS-1:0]  sh_dp;
    logic               snap;
    logic [7:0]         pat;

    assign snap = (cnt == '0) && (idx == '0);

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

`ifdef SEG_SCAN_LEADZERO_EN
    logic [DIGITS-1:0] lz_sup;

    // Walk down from the top digit; the zero run survives disabled digits.
    always_comb begin
        logic run;
        run    = 1'b1;
        lz_sup = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_sup[i] = run && sh_en[i] && (sh_nib[i] == 4'h0);
            run       = run && (!sh_en[i] || (sh_nib[i] == 4'h0));
        end
    end
`endif

    always_comb begin
        pat = sh_en[idx] ? seg_decode(sh_nib[idx]) : 8'hBF;
`ifdef SEG_SCAN_LEADZERO_EN
        if (lz_sup[idx]) pat = 8'hFF;
`endif
        if (sh_dp[idx]) pat[7] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_BLANK;
            cnt         <= '0;
            idx         <= '0;
            for (int i = 0; i < DIGITS; i++) sh_nib[i] <= '0;
            sh_en       <= '0;
            sh_dp       <= '0;
            dataout     <= 8'hFF;
            bit_out     <= '1;
            frame_start <= 1'b0;
        end else begin
            // Output stage: registered view of the current (idx, cnt).
            frame_start <= snap;
            if (state == ST_BLANK) begin
                bit_out <= '1;
                dataout <= 8'hFF;
            end else begin
                bit_out <= ~(DIGITS'(1) << idx);
                dataout <= pat;
            end

            if (snap) begin
                for (int i = 0; i < DIGITS; i++) sh_nib[i] <= digit_data[4*i +: 4];
                sh_en <= digit_en;
                sh_dp <= dp;
            end

            // Slot sequencing: state always describes the phase of cnt.
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= ST_BLANK;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_BLANK_LAST) state <= ST_DRIVE;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles):
// frame-level reference model, vector table and corner-case sequences.
module tb_seg_scan_driver;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [15:0] digit_data = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp = '0;
    logic [7:0]  dataout;
    logic [3:0]  bit_out;
    logic        frame_start;

    seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .digit_data(digit_data), .digit_en(digit_en),
        .dp(dp), .dataout(dataout), .bit_out(bit_out), .frame_start(frame_start));

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          kk = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_en = '0;
    logic [3:0]  m_dp = '0;
    int          blank_run = 0;
    logic [3:0]  prev_bo = 4'hF;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      en;
        logic [3:0]      dpv;
        logic [3:0][7:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, kk, act, exp);
        end
    endtask

    function automatic logic [7:0] model_pat(input int d);
        logic [7:0] p;
        logic [3:0] nib;
        nib = m_data[4*d +: 4];
        p = m_en[d] ? SEG_TAB[nib] : 8'hBF;
`ifdef SEG_SCAN_LEADZERO_EN
        begin
            int top;
            top = -1;
            for (int j = 0; j < DIGITS; j++)
                if (m_en[j] && m_data[4*j +: 4] != 4'h0) top = j;
            if (d > 0 && m_en[d] && nib == 4'h0 && d > top) p = 8'hFF;
        end
`endif
        if (m_dp[d]) p[7] = 1'b0;
        return p;
    endfunction

    task automatic step();
        int pos, slot, c;
        logic [3:0] e_bo;
        logic [7:0] e_do;
        @(posedge CLK);
        kk++;
        pos = (kk - 1) % FRAME;
        if (pos == 0) begin
            m_data = digit_data;
            m_en   = digit_en;
            m_dp   = dp;
        end
        #1;
        slot = pos / SCAN_DIV;
        c    = pos % SCAN_DIV;
        if (c < BLANK_CYC) begin
            e_bo = 4'hF;
            e_do = 8'hFF;
        end else begin
            e_bo = ~(4'b0001 << slot);
            e_do = model_pat(slot);
        end
        chk("frame_start", frame_start, (pos == 0));
        chk("bit_out", bit_out, e_bo);
        chk("dataout", dataout, e_do);
        chk("one_select", ($countones(~bit_out) <= 1), 1);
        if (bit_out == 4'hF) begin
            blank_run++;
        end else begin
            if (prev_bo == 4'hF) chk("blank_gap", (blank_run >= BLANK_CYC), 1);
            else                 chk("no_direct_switch", (bit_out == prev_bo), 1);
            blank_run = 0;
        end
        prev_bo = bit_out;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET_N   = 1'b1;
        kk        = 0;
        blank_run = 0;
        prev_bo   = 4'hF;
    endtask

    initial begin
        vecs[0] = '{16'h3A71, 4'hF,    4'h0,    {8'hB0, 8'h88, 8'hF8, 8'hF9}};
        vecs[1] = '{16'h3A71, 4'b1011, 4'b0100, {8'hB0, 8'h3F, 8'hF8, 8'hF9}};
`ifdef SEG_SCAN_LEADZERO_EN
        vecs[2] = '{16'h0050, 4'hF,    4'h0,    {8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vecs[6] = '{16'h0103, 4'b1011, 4'b1000, {8'h7F, 8'hBF, 8'hFF, 8'hB0}};
`else
        vecs[2] = '{16'h0050, 4'hF,    4'h0,    {8'hC0, 8'hC0, 8'h92, 8'hC0}};
        vecs[6] = '{16'h0103, 4'b1011, 4'b1000, {8'h40, 8'hBF, 8'hC0, 8'hB0}};
`endif
        vecs[3] = '{16'hFEDC, 4'hF,    4'hF,    {8'h0E, 8'h06, 8'h21, 8'h46}};
        vecs[4] = '{16'h8642, 4'h0,    4'h0,    {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
        vecs[5] = '{16'h9B05, 4'hF,    4'b0001, {8'h90, 8'h83, 8'hC0, 8'h12}};

        digit_data = 16'h3A71;
        digit_en   = 4'hF;
        dp         = 4'h0;
        #2 RESET_N = 1'b0;
        #21;
        chk("reset_bit_out", bit_out, 4'hF);
        chk("reset_dataout", dataout, 8'hFF);
        chk("reset_frame_start", frame_start, 0);
        release_reset();

        // First frame after release, then mid-frame data change.
        for (int t = 1; t <= 40; t++) begin
            if (t == 12) digit_data = 16'hFFFF;
            step();
            if (t == 1)  chk("hs_fs_c1", frame_start, 1);
            if (t == 2)  chk("hs_blank_c2", {bit_out, dataout}, {4'hF, 8'hFF});
            if (t == 3)  chk("hs_d0_c3", {bit_out, dataout}, {4'hE, 8'hF9});
            if (t == 8)  chk("hs_d0_c8", {bit_out, dataout}, {4'hE, 8'hF9});
            if (t == 9)  chk("hs_blank_c9", {bit_out, dataout}, {4'hF, 8'hFF});
            if (t == 16) chk("hs_d1_keep", {bit_out, dataout}, {4'hD, 8'hF8});
            if (t == 24) chk("hs_d2_keep", {bit_out, dataout}, {4'hB, 8'h88});
            if (t == 32) chk("hs_d3_keep", {bit_out, dataout}, {4'h7, 8'hB0});
            if (t == 33) chk("hs_fs_c33", frame_start, 1);
            if (t == 35) chk("hs_new_data", {bit_out, dataout}, {4'hE, 8'h8E});
        end

        // Vector table: one full frame per entry, checked at each slot's last cycle.
        for (int v = 0; v < 7; v++) begin
            digit_data = vecs[v].data;
            digit_en   = vecs[v].en;
            dp         = vecs[v].dpv;
            for (int g = 0; g <= FRAME; g++) begin
                step();
                if ((kk - 1) % FRAME == 0) break;
            end
            for (int p = 1; p < FRAME; p++) begin
                step();
                if (p % SCAN_DIV == SCAN_DIV - 1)
                    chk($sformatf("tbl%0d_d%0d", v, p / SCAN_DIV), dataout, vecs[v].exp[p / SCAN_DIV]);
            end
        end

        // Reset asserted while digit 2 is being driven.
        digit_data = 16'h3A71;
        digit_en   = 4'hF;
        dp         = 4'h0;
        for (int g = 0; g < 2 * FRAME; g++) begin
            step();
            if ((kk - 1) % FRAME == 2 * SCAN_DIV + 4) break;
        end
        chk("pre_reset_drive", {bit_out, dataout}, {4'hB, 8'h88});
        RESET_N = 1'b0;
        #1;
        chk("async_rst_bit_out", bit_out, 4'hF);
        chk("async_rst_dataout", dataout, 8'hFF);
        chk("async_rst_fs", frame_start, 0);
        @(negedge CLK);
        @(negedge CLK);
        release_reset();
        for (int t = 1; t <= 12; t++) begin
            step();
            if (t == 1) chk("rst_restart_fs", frame_start, 1);
            if (t == 3) chk("rst_restart_d0", {bit_out, dataout}, {4'hE, 8'hF9});
        end

        // Randomized inputs changing at arbitrary cycles.
        for (int n = 0; n < 12 * FRAME; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                logic [15:0] d;
                d = 16'($urandom);
                for (int i = 0; i < DIGITS; i++)
                    if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'h0;
                digit_data = d;
                digit_en   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
                dp         = 4'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
